// File: rtl/dff_pipe_bank.sv
// Multi-stage register bank used as a configurable delay line / snapshot buffer.
// Stages s[0..DEPTH-1]: s[0] is the input end and s[DEPTH-1] drives q. Supports synchronous
// reset and preset, a clock enable, and hold / broadcast-load / shift / rotate modes.
// Any stage can be read through tap_q. fill counts the stages written since the last reset.
module dff_pipe_bank #(
    parameter int unsigned     WIDTH      = 8,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pre,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output logic [WIDTH-1:0]           tap_q,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int unsigned SelW  = $clog2(DEPTH);
    localparam int unsigned FillW = $clog2(DEPTH + 1);
    localparam logic [FillW-1:0] FillMax = FillW'(DEPTH);

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeLoad  = 2'b01;
    localparam logic [1:0] ModeShift = 2'b10;
    localparam logic [1:0] ModeRot   = 2'b11;

    // Reject degenerate geometries at elaboration time.
    if (DEPTH < 2) begin : gen_depth_check
        $error("dff_pipe_bank: DEPTH must be at least 2");
    end
    if (WIDTH < 1) begin : gen_width_check
        $error("dff_pipe_bank: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [FillW-1:0] fill_q;
    logic [FillW-1:0] fill_d;

    // Next-state: rst beats pre, pre beats the enable, the enable gates the mode.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s_d[i] = s_q[i];
        end
        fill_d = fill_q;

        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_d[i] = '0;
            end
            fill_d = '0;
        end else if (pre) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_d[i] = PRESET_VAL;
            end
            fill_d = FillMax;
        end else if (en) begin
            unique case (mode)
                ModeHold: begin
                    fill_d = fill_q;
                end
                ModeLoad: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        s_d[i] = d;
                    end
                    fill_d = FillMax;
                end
                ModeShift: begin
                    s_d[0] = d;
                    for (int i = 1; i < DEPTH; i++) begin
                        s_d[i] = s_q[i-1];
                    end
                    // Saturate instead of wrapping once every stage has been written.
                    if (fill_q != FillMax) begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ModeRot: begin
                    // Occupancy is a write count, so rotating leaves it alone.
                    s_d[0] = s_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        s_d[i] = s_q[i-1];
                    end
                end
                default: begin
                    fill_d = fill_q;
                end
            endcase
        end
    end

    // State registers; reset and preset are folded into the next-state logic.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            s_q[i] <= s_d[i];
        end
        fill_q <= fill_d;
    end

    // Tap mux; a select beyond the last stage (non-power-of-2 DEPTH) reads as zero.
    always_comb begin
        tap_q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == SelW'(i)) begin
                tap_q = s_q[i];
            end
        end
    end

    // Outputs come straight from registered state, no extra output stage.
    always_comb begin
        q     = s_q[DEPTH-1];
        q_bar = ~s_q[DEPTH-1];
        fill  = fill_q;
        full  = (fill_q == FillMax);
    end

endmodule
